// File: rtl/dram_arbiter_pkg.sv
// Shared types for the CPU/DMA DRAM port arbiter.
package dram_arb_pkg;

  typedef enum logic {
    ARB       = 1'b0,
    DMA_BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } arb_owner_e;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

endpackage

// File: rtl/dram_arbiter_sat_counter.sv
// Saturating up-counter. Clear wins over increment, and only at_max is exported.
module arb_sat_counter #(
  parameter  int unsigned MAX = 4,
  localparam int unsigned W   = $clog2(MAX + 2)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Arbitrates one synchronous-read DRAM port between the CPU LSU and a DMA master,
// with CPU priority, a DMA starvation bound and an optional DMA burst lock.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned BURST_MAX  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  input  logic [3:0]        cpu_req_wstrb,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  input  logic [DATA_W-1:0] cpu_req_wdata,
  output logic              cpu_req_ready,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rsp_rdata,
  input  logic              dma_req_valid,
  input  logic [3:0]        dma_req_wstrb,
  input  logic [ADDR_W-1:0] dma_req_addr,
  input  logic [DATA_W-1:0] dma_req_wdata,
  output logic              dma_req_ready,
  output logic              dma_rsp_valid,
  output logic [DATA_W-1:0] dma_rsp_rdata,
  input  logic              dma_req_lock,
  input  logic              dma_req_last,
  output logic [ADDR_W-1:0] dram_a,
  output logic [3:0]        dram_we,
  output logic [DATA_W-1:0] dram_din,
  input  logic [DATA_W-1:0] dram_spo,
  output arb_state_e        dbg_state_o
);

  // Handshake: a request transfers in the cycle where valid && ready are both
  // high; ready may be high with no request and never depends on dram_spo.

  arb_state_e state_q;
  arb_owner_e rsp_owner_q, rsp_owner_d;
  logic       rsp_pend_q, rsp_pend_d;

  logic forced, cpu_acc, dma_acc;
  logic burst_enter, burst_exit;
  logic starve_inc, starve_clr, starve_at_max;
  logic beat_inc, beat_clr, beat_at_max;

  always_comb begin
    forced        = (state_q == ARB) && dma_req_valid && starve_at_max;
    cpu_req_ready = rst_n && (state_q == ARB) && !forced;
    dma_req_ready = rst_n && ((state_q == DMA_BURST) || !cpu_req_valid || forced);
    cpu_acc       = cpu_req_valid && cpu_req_ready;
    dma_acc       = dma_req_valid && dma_req_ready;
    // beat_at_max in ARB only holds when a burst could never exceed one beat.
    burst_enter   = (state_q == ARB) && dma_acc && dma_req_lock && !dma_req_last
                    && !beat_at_max;
    burst_exit    = (state_q == DMA_BURST)
                    && (!dma_req_valid || (dma_acc && (dma_req_last || beat_at_max)));
    starve_inc    = dma_req_valid && !dma_req_ready;
    starve_clr    = !dma_req_valid || dma_acc || burst_exit;
    beat_inc      = burst_enter || ((state_q == DMA_BURST) && dma_acc && !burst_exit);
    beat_clr      = burst_exit;
  end

  arb_sat_counter #(.MAX(STARVE_MAX)) starve_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (starve_inc),
    .clr_i    (starve_clr),
    .at_max_o (starve_at_max)
  );

  // Counts beats already taken; the beat accepted at BURST_MAX-1 closes the burst.
  arb_sat_counter #(.MAX(BURST_MAX - 1)) beat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (beat_inc),
    .clr_i    (beat_clr),
    .at_max_o (beat_at_max)
  );

  always_comb begin
    dram_a   = '0;
    dram_we  = '0;
    dram_din = '0;
    if (cpu_acc) begin
      dram_a   = cpu_req_addr;
      dram_we  = cpu_req_wstrb;
      dram_din = cpu_req_wdata;
    end else if (dma_acc) begin
      dram_a   = dma_req_addr;
      dram_we  = dma_req_wstrb;
      dram_din = dma_req_wdata;
    end
  end

  always_comb begin
    rsp_pend_d  = (cpu_acc && (cpu_req_wstrb == WSTRB_READ))
               || (dma_acc && (dma_req_wstrb == WSTRB_READ));
    rsp_owner_d = cpu_acc ? OWN_CPU : OWN_DMA;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= OWN_CPU;
    end else begin
      rsp_pend_q  <= rsp_pend_d;
      rsp_owner_q <= rsp_owner_d;
      if (burst_enter) begin
        state_q <= DMA_BURST;
      end else if (burst_exit) begin
        state_q <= ARB;
      end
    end
  end

  // Read data comes straight from the DRAM output register in the response cycle.
  always_comb begin
    cpu_rsp_valid = rst_n && rsp_pend_q && (rsp_owner_q == OWN_CPU);
    dma_rsp_valid = rst_n && rsp_pend_q && (rsp_owner_q == OWN_DMA);
    cpu_rsp_rdata = cpu_rsp_valid ? dram_spo : '0;
    dma_rsp_rdata = dma_rsp_valid ? dram_spo : '0;
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model with a DRAM behavioural model.
module tb_dram_arbiter;
  import dram_arb_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int BMAX = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req_valid, dma_req_valid, dma_req_lock, dma_req_last;
  logic [3:0]    cpu_req_wstrb, dma_req_wstrb;
  logic [AW-1:0] cpu_req_addr, dma_req_addr;
  logic [DW-1:0] cpu_req_wdata, dma_req_wdata;
  logic          cpu_req_ready, dma_req_ready, cpu_rsp_valid, dma_rsp_valid;
  logic [DW-1:0] cpu_rsp_rdata, dma_rsp_rdata;
  logic [AW-1:0] dram_a;
  logic [3:0]    dram_we;
  logic [DW-1:0] dram_din, dram_spo;
  arb_state_e    dbg_state;

  logic          ld_en;
  logic [7:0]    ld_addr;
  logic [DW-1:0] ld_data;
  logic [DW-1:0] dram_mem [0:255];
  logic [DW-1:0] ref_mem  [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .BURST_MAX(BMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_req_wstrb(cpu_req_wstrb), .cpu_req_addr(cpu_req_addr),
    .cpu_req_wdata(cpu_req_wdata), .cpu_req_ready(cpu_req_ready),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
    .dma_req_valid(dma_req_valid), .dma_req_wstrb(dma_req_wstrb), .dma_req_addr(dma_req_addr),
    .dma_req_wdata(dma_req_wdata), .dma_req_ready(dma_req_ready),
    .dma_rsp_valid(dma_rsp_valid), .dma_rsp_rdata(dma_rsp_rdata),
    .dma_req_lock(dma_req_lock), .dma_req_last(dma_req_last),
    .dram_a(dram_a), .dram_we(dram_we), .dram_din(dram_din), .dram_spo(dram_spo),
    .dbg_state_o(dbg_state)
  );

  // DRAM macro: byte-enabled write, registered read of the presented address.
  always @(posedge clk) begin
    if (ld_en) begin
      dram_mem[ld_addr] <= ld_data;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (dram_we[b]) dram_mem[dram_a[7:0]][b*8 +: 8] <= dram_din[b*8 +: 8];
      end
    end
    dram_spo <= dram_mem[dram_a[7:0]];
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [3:0] strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    cpu_req_valid = 1'b0; cpu_req_wstrb = 4'h0; cpu_req_addr = '0; cpu_req_wdata = '0;
    dma_req_valid = 1'b0; dma_req_wstrb = 4'h0; dma_req_addr = '0; dma_req_wdata = '0;
    dma_req_lock  = 1'b0; dma_req_last  = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_req_valid = 1'b1; dma_req_valid = 1'b1; cpu_req_wstrb = 4'hF; dma_req_wstrb = 4'hF;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (cpu_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready: got %b want 0", cpu_req_ready); end
    n_checks++; if (dma_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_dma_ready: got %b want 0", dma_req_ready); end
    n_checks++; if (dram_we !== 4'h0) begin n_fail++; $display("FAIL rst_dram_we: got %h want 0", dram_we); end
    n_checks++; if ({cpu_rsp_valid, dma_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 00", {cpu_rsp_valid, dma_rsp_valid}); end
    n_checks++; if (dbg_state !== ARB) begin n_fail++; $display("FAIL rst_state: got %0d want ARB", dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
  endtask

  task automatic test_cpu_read();
    apply_reset();
    load(8'h10, 32'hDEADBEEF);
    cpu_req_valid = 1'b1; cpu_req_wstrb = WSTRB_READ; cpu_req_addr = 16'h0010;
    #1;
    n_checks++; if (cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_ready: got %b want 1", cpu_req_ready); end
    n_checks++; if (dram_a !== 16'h0010 || dram_we !== 4'h0) begin n_fail++; $display("FAIL rd_drive: got a=%h we=%h want a=0010 we=0", dram_a, dram_we); end
    @(negedge clk);
    cpu_req_valid = 1'b0;
    #1;
    n_checks++; if (cpu_rsp_valid !== 1'b1 || cpu_rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rsp: got v=%b d=%h want v=1 d=deadbeef", cpu_rsp_valid, cpu_rsp_rdata); end
    n_checks++; if (dma_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_dma_quiet: got %b want 0", dma_rsp_valid); end
    @(negedge clk);
    #1;
    n_checks++; if (cpu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_rsp_once: got %b want 0", cpu_rsp_valid); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    apply_reset();
    cpu_req_valid = 1'b1; cpu_req_addr = 16'd1;
    dma_req_valid = 1'b1; dma_req_addr = 16'd2;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_checks++; if (cpu_req_ready !== (i % 5 != 4)) begin n_fail++; $display("FAIL cont_cpu_ready[%0d]: got %b want %b", i, cpu_req_ready, (i % 5 != 4)); end
      n_checks++; if (dma_req_ready !== (i % 5 == 4)) begin n_fail++; $display("FAIL cont_dma_ready[%0d]: got %b want %b", i, dma_req_ready, (i % 5 == 4)); end
      if (i > 0) begin
        n_checks++; if (dma_rsp_valid !== ((i - 1) % 5 == 4)) begin n_fail++; $display("FAIL cont_dma_rsp[%0d]: got %b want %b", i, dma_rsp_valid, ((i - 1) % 5 == 4)); end
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_locked_burst();
    apply_reset();
    cpu_req_valid = 1'b1; cpu_req_addr = 16'd3;
    dma_req_valid = 1'b1; dma_req_addr = 16'd4; dma_req_lock = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) dma_req_last = 1'b1;
      if (i == 7) begin dma_req_valid = 1'b0; dma_req_lock = 1'b0; dma_req_last = 1'b0; end
      #1;
      n_checks++; if (cpu_req_ready !== (i < 4 || i == 7)) begin n_fail++; $display("FAIL lock_cpu_ready[%0d]: got %b want %b", i, cpu_req_ready, (i < 4 || i == 7)); end
      n_checks++; if (dma_req_ready !== (i >= 4 && i <= 6)) begin n_fail++; $display("FAIL lock_dma_ready[%0d]: got %b want %b", i, dma_req_ready, (i >= 4 && i <= 6)); end
      n_checks++; if ((dbg_state == DMA_BURST) !== (i == 5 || i == 6)) begin n_fail++; $display("FAIL lock_state[%0d]: got %0d", i, dbg_state); end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_burst_cap();
    int beats = 0;
    apply_reset();
    dma_req_valid = 1'b1; dma_req_addr = 16'd8; dma_req_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) begin cpu_req_valid = 1'b1; cpu_req_addr = 16'd9; end
      #1;
      if (dma_req_valid && dma_req_ready) beats++;
      if (i > 0) begin
        n_checks++; if (cpu_req_ready !== (i >= 8)) begin n_fail++; $display("FAIL cap_cpu_ready[%0d]: got %b want %b", i, cpu_req_ready, (i >= 8)); end
      end
      n_checks++; if (dma_req_ready !== (i <= 7)) begin n_fail++; $display("FAIL cap_dma_ready[%0d]: got %b want %b", i, dma_req_ready, (i <= 7)); end
      @(negedge clk);
    end
    n_checks++; if (beats != BMAX) begin n_fail++; $display("FAIL cap_beats: got %0d want %0d", beats, BMAX); end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [DW-1:0] exp_w;
    apply_reset();
    load(8'd5, 32'hAABBCCDD);
    exp_w = merge(32'hAABBCCDD, 32'h12345678, 4'b0011);
    cpu_req_valid = 1'b1; cpu_req_wstrb = 4'b0011; cpu_req_addr = 16'd5; cpu_req_wdata = 32'h12345678;
    #1;
    n_checks++; if (dram_we !== 4'b0011 || dram_a !== 16'd5 || dram_din !== 32'h12345678) begin n_fail++; $display("FAIL wr_drive: got we=%h a=%h d=%h want we=3 a=5 d=12345678", dram_we, dram_a, dram_din); end
    @(negedge clk);
    idle_inputs();
    dma_req_valid = 1'b1; dma_req_addr = 16'd5;
    #1;
    n_checks++; if (dma_req_ready !== 1'b1 || dram_we !== 4'h0) begin n_fail++; $display("FAIL wr_dma_rd: got ready=%b we=%h want ready=1 we=0", dma_req_ready, dram_we); end
    n_checks++; if (cpu_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rsp: got %b want 0", cpu_rsp_valid); end
    @(negedge clk);
    dma_req_valid = 1'b0;
    #1;
    n_checks++; if (dma_rsp_valid !== 1'b1 || dma_rsp_rdata !== exp_w) begin n_fail++; $display("FAIL wr_merged: got v=%b d=%h want v=1 d=%h", dma_rsp_valid, dma_rsp_rdata, exp_w); end
    n_checks++; if (cpu_rsp_rdata !== '0) begin n_fail++; $display("FAIL wr_cpu_rdata: got %h want 0", cpu_rsp_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_burst();
    apply_reset();
    dma_req_valid = 1'b1; dma_req_addr = 16'd6; dma_req_lock = 1'b1;
    #1;
    n_checks++; if (dma_req_ready !== 1'b1) begin n_fail++; $display("FAIL rb_first_beat: got %b want 1", dma_req_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (dbg_state !== DMA_BURST) begin n_fail++; $display("FAIL rb_in_burst: got %0d want DMA_BURST", dbg_state); end
    @(negedge clk);
    rst_n = 1'b0; cpu_req_valid = 1'b1; cpu_req_addr = 16'd7;
    #1;
    n_checks++; if ({cpu_req_ready, dma_req_ready, cpu_rsp_valid, dma_rsp_valid} !== 4'b0000) begin n_fail++; $display("FAIL rb_in_reset: got %b want 0000", {cpu_req_ready, dma_req_ready, cpu_rsp_valid, dma_rsp_valid}); end
    @(negedge clk);
    rst_n = 1'b1; dma_req_valid = 1'b0; dma_req_lock = 1'b0;
    #1;
    n_checks++; if ({cpu_rsp_valid, dma_rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rb_no_rsp: got %b want 00", {cpu_rsp_valid, dma_rsp_valid}); end
    n_checks++; if (dbg_state !== ARB || cpu_req_ready !== 1'b1) begin n_fail++; $display("FAIL rb_cpu_grant: got state=%0d ready=%b want ARB 1", dbg_state, cpu_req_ready); end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q[$];
    arb_owner_e    own_q[$];
    int            m_starve, m_beats;
    bit            m_burst, forced, e_cr, e_dr, cacc, dacc, e_cv, e_dv;
    logic [AW-1:0] e_a;
    logic [3:0]    e_we;
    logic [DW-1:0] e_din, e_crd, e_drd;
    apply_reset();
    for (int a = 32; a < 48; a++) begin
      ref_mem[a] = $urandom;
      load(8'(a), ref_mem[a]);
    end
    m_starve = 0; m_beats = 0; m_burst = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      cpu_req_valid = ($urandom_range(0, 3) != 0);
      cpu_req_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      cpu_req_addr  = AW'(32 + $urandom_range(0, 15));
      cpu_req_wdata = $urandom;
      dma_req_valid = ($urandom_range(0, 2) != 0);
      dma_req_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      dma_req_addr  = AW'(32 + $urandom_range(0, 15));
      dma_req_wdata = $urandom;
      dma_req_lock  = ($urandom_range(0, 2) == 0);
      dma_req_last  = ($urandom_range(0, 5) == 0);
      #1;
      forced = !m_burst && dma_req_valid && (m_starve == SMAX);
      e_cr   = !m_burst && !forced;
      e_dr   = m_burst || !cpu_req_valid || forced;
      cacc   = cpu_req_valid && e_cr;
      dacc   = dma_req_valid && e_dr;
      e_a = '0; e_we = '0; e_din = '0;
      if (cacc) begin e_a = cpu_req_addr; e_we = cpu_req_wstrb; e_din = cpu_req_wdata; end
      else if (dacc) begin e_a = dma_req_addr; e_we = dma_req_wstrb; e_din = dma_req_wdata; end
      e_cv = 0; e_dv = 0; e_crd = '0; e_drd = '0;
      if (exp_q.size() > 0) begin
        if (own_q[0] == OWN_CPU) begin e_cv = 1; e_crd = exp_q[0]; end
        else begin e_dv = 1; e_drd = exp_q[0]; end
        void'(exp_q.pop_front()); void'(own_q.pop_front());
      end
      n_checks++; if ({cpu_req_ready, dma_req_ready} !== {e_cr, e_dr}) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, {cpu_req_ready, dma_req_ready}, {e_cr, e_dr}); end
      n_checks++; if (dram_a !== e_a || dram_we !== e_we || dram_din !== e_din) begin n_fail++; $display("FAIL rnd_dram[%0d]: got a=%h we=%h d=%h want a=%h we=%h d=%h", cyc, dram_a, dram_we, dram_din, e_a, e_we, e_din); end
      n_checks++; if ({cpu_rsp_valid, dma_rsp_valid} !== {e_cv, e_dv}) begin n_fail++; $display("FAIL rnd_rsp_valid[%0d]: got %b want %b", cyc, {cpu_rsp_valid, dma_rsp_valid}, {e_cv, e_dv}); end
      n_checks++; if (cpu_rsp_rdata !== e_crd || dma_rsp_rdata !== e_drd) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h/%h want %h/%h", cyc, cpu_rsp_rdata, dma_rsp_rdata, e_crd, e_drd); end
      n_checks++; if ((dbg_state == DMA_BURST) !== m_burst) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want burst=%b", cyc, dbg_state, m_burst); end
      if (cacc || dacc) begin
        if (e_we == WSTRB_READ) begin
          exp_q.push_back(ref_mem[e_a[7:0]]);
          own_q.push_back(cacc ? OWN_CPU : OWN_DMA);
        end else begin
          ref_mem[e_a[7:0]] = merge(ref_mem[e_a[7:0]], e_din, e_we);
        end
      end
      m_starve = (dma_req_valid && !e_dr) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
      if (!m_burst) begin
        if (dacc && dma_req_lock && !dma_req_last && BMAX > 1) begin m_burst = 1; m_beats = 1; end
      end else if (!dma_req_valid) begin
        m_burst = 0;
      end else begin
        m_beats++;
        if (dma_req_last || m_beats == BMAX) m_burst = 0;
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_cpu_read();
    test_contention();
    test_locked_burst();
    test_burst_cap();
    test_write_read();
    test_reset_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
